// File: rtl/rv32im_alu_unit.sv
// Registered RV32IM integer execute unit: every ALU, multiply and divide op
// completes in one cycle and is held in alu_o until the next valid issue.
module rv32im_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  input  logic [XLEN-1:0] aluoperand_1_i,
  input  logic [XLEN-1:0] aluoperand_2_i,
  input  logic [4:0]      alu_opcode_i,
  output logic [XLEN-1:0] alu_o,
  output logic            alu_valid_o
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  logic [XLEN-1:0]   opA, opB, result_d, result_q;
  logic [4:0]        shamt;
  logic              mulSignA, mulSignB;
  logic [2*XLEN-1:0] mulA, mulB, product;
  logic              divSigned, negA, negB, divZero;
  logic [XLEN-1:0]   absA, absB, quoMag, remMag, quotient, remainder;
  logic              valid_q;

  assign opA   = aluoperand_1_i;
  assign opB   = aluoperand_2_i;
  assign shamt = opB[4:0];

  // One shared multiplier: sign-extending to 2*XLEN makes the low half of the
  // product correct for every signedness combination.
  assign mulSignA = ((alu_opcode_i == OP_MULH) || (alu_opcode_i == OP_MULHSU)) && opA[XLEN-1];
  assign mulSignB = (alu_opcode_i == OP_MULH) && opB[XLEN-1];
  assign mulA     = {{XLEN{mulSignA}}, opA};
  assign mulB     = {{XLEN{mulSignB}}, opB};
  assign product  = mulA * mulB;

  // Signed divide runs on magnitudes; the overflow case falls out naturally
  // because negating 0x80000000 wraps back to itself.
  assign divSigned = (alu_opcode_i == OP_DIV) || (alu_opcode_i == OP_REM);
  assign negA      = divSigned && opA[XLEN-1];
  assign negB      = divSigned && opB[XLEN-1];
  assign absA      = negA ? (~opA + 1'b1) : opA;
  assign absB      = negB ? (~opB + 1'b1) : opB;
  assign divZero   = (opB == '0);
  assign quoMag    = divZero ? '0 : (absA / absB);
  assign remMag    = divZero ? '0 : (absA % absB);
  assign quotient  = (negA ^ negB) ? (~quoMag + 1'b1) : quoMag;
  assign remainder = negA ? (~remMag + 1'b1) : remMag;

  always_comb begin
    result_d = '0;
    case (alu_opcode_i)
      OP_ADD:    result_d = opA + opB;
      OP_SUB:    result_d = opA - opB;
      OP_SLL:    result_d = opA << shamt;
      OP_SLT:    result_d = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      OP_SLTU:   result_d = {{(XLEN-1){1'b0}}, (opA < opB)};
      OP_XOR:    result_d = opA ^ opB;
      OP_SRL:    result_d = opA >> shamt;
      OP_SRA:    result_d = $unsigned($signed(opA) >>> shamt);
      OP_OR:     result_d = opA | opB;
      OP_AND:    result_d = opA & opB;
      OP_MUL:    result_d = product[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result_d = product[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU:   result_d = divZero ? '1 : quotient;
      OP_REM,
      OP_REMU:   result_d = divZero ? opA : remainder;
      default:   result_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= alu_valid_i;
      if (alu_valid_i) begin
        result_q <= result_d;
      end
    end
  end

  assign alu_o       = result_q;
  assign alu_valid_o = valid_q;

endmodule

// File: tb/tb_rv32im_alu_unit.sv
// Self-checking bench for rv32im_alu_unit: directed vector table, reset and
// hold sequences, then randomized ops checked against a behavioural model.
module tb_rv32im_alu_unit;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        validIn;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  opcode;
  logic [31:0] aluOut;
  logic        validOut;

  int          checkCount;
  int          failCount;
  logic [31:0] expHeld;
  vec_t        vecs[$];

  rv32im_alu_unit #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .alu_valid_i    (validIn),
    .aluoperand_1_i (opA),
    .aluoperand_2_i (opB),
    .alu_opcode_i   (opcode),
    .alu_o          (aluOut),
    .alu_valid_o    (validOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference built from wide integer arithmetic
  function automatic logic [31:0] refModel(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = 64'(ua * ub); return p[31:0]; end
      5'd11: begin p = 64'(sa * sb); return p[63:32]; end
      5'd12: begin p = 64'(sa * ub); return p[63:32]; end
      5'd13: begin p = 64'(ua * ub); return p[63:32]; end
      5'd14: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
      5'd15: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
      5'd16: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      5'd17: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic addVec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive inputs just after a rising edge, then step past the next one
  task automatic applyStimulus(input logic valid, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    validIn = valid;
    opcode  = op;
    opA     = a;
    opB     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rstN       = 1'b0;
    validIn    = 1'b0;
    opA        = '0;
    opB        = '0;
    opcode     = '0;

    // Directed table
    addVec(5'd0,  32'h20, 32'h5, 32'h25);
    addVec(5'd1,  32'h20, 32'h5, 32'h1B);
    addVec(5'd2,  32'h20, 32'h5, 32'h400);
    addVec(5'd3,  32'h20, 32'h5, 32'h0);
    addVec(5'd4,  32'h20, 32'h5, 32'h0);
    addVec(5'd5,  32'h20, 32'h5, 32'h25);
    addVec(5'd6,  32'h20, 32'h5, 32'h1);
    addVec(5'd7,  32'h20, 32'h5, 32'h1);
    addVec(5'd8,  32'h20, 32'h5, 32'h25);
    addVec(5'd9,  32'h20, 32'h5, 32'h0);
    addVec(5'd10, 32'h20, 32'h5, 32'hA0);
    addVec(5'd11, 32'h20, 32'h5, 32'h0);
    addVec(5'd12, 32'h20, 32'h5, 32'h0);
    addVec(5'd13, 32'h20, 32'h5, 32'h0);
    addVec(5'd14, 32'h20, 32'h5, 32'h6);
    addVec(5'd15, 32'h20, 32'h5, 32'h6);
    addVec(5'd16, 32'h20, 32'h5, 32'h2);
    addVec(5'd17, 32'h20, 32'h5, 32'h2);
    addVec(5'd3,  32'hFFFF_FFF0, 32'h5, 32'h1);
    addVec(5'd4,  32'hFFFF_FFF0, 32'h5, 32'h0);
    addVec(5'd7,  32'hFFFF_FFF0, 32'h5, 32'hFFFF_FFFF);
    addVec(5'd6,  32'hFFFF_FFF0, 32'h5, 32'h07FF_FFFF);
    addVec(5'd11, 32'hFFFF_FFF0, 32'h5, 32'hFFFF_FFFF);
    addVec(5'd13, 32'hFFFF_FFF0, 32'h5, 32'h4);
    addVec(5'd12, 32'hFFFF_FFF0, 32'h5, 32'hFFFF_FFFF);
    addVec(5'd14, 32'hFFFF_FFF0, 32'h5, 32'hFFFF_FFFD);
    addVec(5'd16, 32'hFFFF_FFF0, 32'h5, 32'hFFFF_FFFF);
    addVec(5'd14, 32'h1234, 32'h0, 32'hFFFF_FFFF);
    addVec(5'd15, 32'h1234, 32'h0, 32'hFFFF_FFFF);
    addVec(5'd16, 32'h1234, 32'h0, 32'h1234);
    addVec(5'd17, 32'h1234, 32'h0, 32'h1234);
    addVec(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    addVec(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    addVec(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    addVec(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    addVec(5'd2,  32'h1, 32'h21, 32'h2);
    addVec(5'd0,  32'h7, 32'h9, 32'h10);
    addVec(5'd31, 32'h5, 32'h6, 32'h0);

    // Reset holds outputs low even with a valid op present
    applyStimulus(1'b1, 5'd0, 32'h1, 32'h2);
    checkOutput("reset_cycle1_alu", aluOut, 32'h0);
    checkOutput("reset_cycle1_valid", {31'b0, validOut}, 32'h0);
    applyStimulus(1'b1, 5'd0, 32'h1, 32'h2);
    checkOutput("reset_cycle2_alu", aluOut, 32'h0);
    checkOutput("reset_cycle2_valid", {31'b0, validOut}, 32'h0);
    rstN = 1'b1;
    applyStimulus(1'b1, 5'd0, 32'h1, 32'h2);
    checkOutput("post_reset_alu", aluOut, 32'h3);
    checkOutput("post_reset_valid", {31'b0, validOut}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_op%0d", i, vecs[i].op), aluOut, vecs[i].exp);
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, validOut}, 32'h1);
    end

    // Hold: establish a nonzero result, then idle with toggling operands
    applyStimulus(1'b1, 5'd8, 32'hA5A5_0000, 32'h0000_5A5A);
    checkOutput("hold_setup", aluOut, 32'hA5A5_5A5A);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, $urandom, $urandom);
      checkOutput($sformatf("hold%0d_alu", i), aluOut, 32'hA5A5_5A5A);
      checkOutput($sformatf("hold%0d_valid", i), {31'b0, validOut}, 32'h0);
    end

    // Randomized back-to-back traffic with occasional bubbles
    expHeld = aluOut;
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      v  = ($urandom_range(0, 7) != 0);
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(0, 40));
        default: ;
      endcase
      applyStimulus(v, op, a, b);
      if (v) expHeld = refModel(op, a, b);
      checkOutput($sformatf("rand%0d_op%0d", i, op), aluOut, expHeld);
      checkOutput($sformatf("rand%0d_valid", i), {31'b0, validOut}, {31'b0, v});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
